tensor_cmd_dispatch: RTL and testbench

TENSOR_CMD_DISPATCH -- requirements
Module: tensor_cmd_dispatch

---
 rtl/tensor_cmd_dispatch.sv | 179 +++++++++++++++++
 tb/tb_tensor_cmd_dispatch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_cmd_dispatch.sv
// Tensor command dispatcher: a command FIFO feeding NUM_CORES tensor cores round-robin.
// Optional macro TENSOR_CMD_DISPATCH_PERF_CNT_EN enables the 32-bit issue/done counters.

module tensor_cmd_core_fsm (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sel_i,
  input  logic ready_i,
  input  logic done_i,
  output logic valid_o,
  output logic issue_o,
  output logic busy_o,
  output logic idle_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  state_t state_q, state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A core selected while idle offers the command in that same cycle and
  // parks in ISSUE only if the core does not take it immediately.
  always_comb begin
    state_d = state_q;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        valid_o = sel_i;
        if (sel_i) state_d = ready_i ? BUSY : ISSUE;
      end
      ISSUE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = BUSY;
      end
      BUSY:    if (done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign issue_o = (state_q == ISSUE);
  assign busy_o  = (state_q == BUSY);
  assign idle_o  = (state_q == IDLE);
endmodule

module tensor_cmd_dispatch #(
  parameter int NUM_CORES = 2,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 23,
  parameter int DIM_W     = 16,
  localparam int REQ_W    = 3*ADDR_W + 6*DIM_W + 1,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [REQ_W-1:0]     req_i,
  output logic [NUM_CORES-1:0] core_valid_o,
  input  logic [NUM_CORES-1:0] core_ready_i,
  output logic [REQ_W-1:0]     core_req_o,
  input  logic [NUM_CORES-1:0] core_done_i,
  output logic                 done_o,
  output logic                 idle_o,
  output logic [CNT_W-1:0]     fifo_count_o,
  output logic [31:0]          issue_cnt_o,
  output logic [31:0]          done_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [DEPTH-1:0][REQ_W-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [CNT_W-1:0]            count;
  logic [CW-1:0]               rr_ptr;
  logic                        push, pop;

  logic [NUM_CORES-1:0] sel_vec, issue_vec, busy_vec, idle_vec, hs_vec, done_acc;

  assign req_ready_o  = (count != CNT_W'(DEPTH));
  assign push         = req_valid_i && req_ready_o;
  assign hs_vec       = core_valid_o & core_ready_i;
  assign pop          = |hs_vec;
  assign done_acc     = core_done_i & busy_vec;
  assign fifo_count_o = count;
  assign core_req_o   = mem[rd_ptr];
  assign idle_o       = (count == '0) && (&idle_vec);

  // Payload storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= req_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Selection looks only at registered state, so it is stable within a cycle
  // and a core returning to IDLE is not picked until the following cycle.
  always_comb begin
    logic          found;
    logic [CW-1:0] cand;
    sel_vec = '0;
    found   = 1'b0;
    cand    = '0;
    if ((count != '0) && !(|issue_vec)) begin
      for (int off = 1; off <= NUM_CORES; off++) begin
        cand = CW'((int'(rr_ptr) + off) % NUM_CORES);
        if (!found && idle_vec[cand]) begin
          sel_vec[cand] = 1'b1;
          found         = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= CW'(NUM_CORES - 1);
      done_o <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++)
        if (hs_vec[k]) rr_ptr <= CW'(k);
      done_o <= |done_acc;
    end
  end

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
    tensor_cmd_core_fsm u_fsm (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .sel_i   (sel_vec[k]),
      .ready_i (core_ready_i[k]),
      .done_i  (core_done_i[k]),
      .valid_o (core_valid_o[k]),
      .issue_o (issue_vec[k]),
      .busy_o  (busy_vec[k]),
      .idle_o  (idle_vec[k])
    );
  end

`ifdef TENSOR_CMD_DISPATCH_PERF_CNT_EN
  logic [31:0] issue_cnt, done_cnt, done_inc;

  always_comb begin
    done_inc = '0;
    for (int k = 0; k < NUM_CORES; k++) done_inc = done_inc + 32'(done_acc[k]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_cnt <= '0;
      done_cnt  <= '0;
    end else begin
      if (pop) issue_cnt <= issue_cnt + 32'd1;
      done_cnt <= done_cnt + done_inc;
    end
  end

  assign issue_cnt_o = issue_cnt;
  assign done_cnt_o  = done_cnt;
`else
  assign issue_cnt_o = '0;
  assign done_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_tensor_cmd_dispatch.sv
// Scoreboard bench for tensor_cmd_dispatch (NUM_CORES=2, DEPTH=4): stimulus queues
// expected issues, a negedge monitor checks every issue handshake.

module tb_tensor_cmd_dispatch;
  localparam int NC    = 2;
  localparam int DEPTH = 4;
  localparam int REQ_W = 3*23 + 6*16 + 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [REQ_W-1:0] req_i = '0;
  logic [NC-1:0]    core_valid_o;
  logic [NC-1:0]    core_ready_i = '0;
  logic [REQ_W-1:0] core_req_o;
  logic [NC-1:0]    core_done_i = '0;
  logic             done_o, idle_o;
  logic [CNT_W-1:0] fifo_count_o;
  logic [31:0]      issue_cnt_o, done_cnt_o;

  tensor_cmd_dispatch #(.NUM_CORES(NC), .DEPTH(DEPTH), .ADDR_W(23), .DIM_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_i(req_i), .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
    .core_req_o(core_req_o), .core_done_i(core_done_i), .done_o(done_o), .idle_o(idle_o),
    .fifo_count_o(fifo_count_o), .issue_cnt_o(issue_cnt_o), .done_cnt_o(done_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct { int core; logic [REQ_W-1:0] p; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  function automatic logic [REQ_W-1:0] mk(input int n);
    logic [191:0] w;
    w = {6{32'(n) * 32'h9E37_79B1 + 32'h0BAD_F00D}};
    return w[REQ_W-1:0];
  endfunction

  function automatic exp_t ex(input int c, input int n);
    exp_t e;
    e.core = c;
    e.p    = mk(n);
    return e;
  endfunction

  // Monitor: every issue handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_ni) begin
      chk("valid_onehot0", 64'($onehot0(core_valid_o)), 64'd1);
      for (int k = 0; k < NC; k++) begin
        if (core_valid_o[k] && core_ready_i[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL issue_unexpected core=%0d actual=%0h expected=none", k, core_req_o);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.core != k || core_req_o !== e.p) begin
              failures++;
              $display("FAIL issue core actual=%0d expected=%0d payload actual=%0h expected=%0h",
                       k, e.core, core_req_o, e.p);
            end
          end
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int n);
    req_i       = mk(n);
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    core_ready_i = '0;
    core_done_i = '0;
    step();
    step();
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    chk("rst_valid", 64'(core_valid_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_idle", 64'(idle_o), 64'd1);
    chk("rst_count", 64'(fifo_count_o), 64'd0);
    chk("rst_issue_cnt", 64'(issue_cnt_o), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt_o), 64'd0);
    rst_ni = 1'b1;
    step();
  endtask

  initial begin
    do_reset();

    // Single command: valid one cycle after the push, then core 0 busy.
    core_ready_i = 2'b01;
    exp_q.push_back(ex(0, 1));
    push(1);
    @(negedge clk);
    chk("t35_valid", 64'(core_valid_o), 64'h1);
    step();
    chk("t35_idle", 64'(idle_o), 64'd0);
    chk("t35_count", 64'(fifo_count_o), 64'd0);
    core_done_i = 2'b01;
    step();
    core_done_i = 2'b00;
    chk("t35_done_pulse", 64'(done_o), 64'd1);
    step();
    chk("t35_done_low", 64'(done_o), 64'd0);
    chk("t35_idle_back", 64'(idle_o), 64'd1);

    // Three commands: core0, core1, third waits for core0 to finish.
    do_reset();
    exp_q.push_back(ex(0, 10));
    exp_q.push_back(ex(1, 11));
    exp_q.push_back(ex(0, 12));
    push(10); push(11); push(12);
    chk("t36_count3", 64'(fifo_count_o), 64'd3);
    core_ready_i = 2'b11;
    step();
    chk("t36_count2", 64'(fifo_count_o), 64'd2);
    step();
    chk("t36_count1", 64'(fifo_count_o), 64'd1);
    step();
    chk("t36_wait_count", 64'(fifo_count_o), 64'd1);
    chk("t36_wait_valid", 64'(core_valid_o), 64'd0);
    core_done_i = 2'b01;
    step();
    core_done_i = 2'b00;
    chk("t36_reissue_valid", 64'(core_valid_o), 64'h1);
    step();
    chk("t36_count0", 64'(fifo_count_o), 64'd0);

    // Coincident completions give one done pulse.
    core_done_i = 2'b11;
    step();
    core_done_i = 2'b00;
    chk("t38_done_pulse", 64'(done_o), 64'd1);
    chk("t38_idle", 64'(idle_o), 64'd1);
`ifdef TENSOR_CMD_DISPATCH_PERF_CNT_EN
    chk("t38_done_cnt", 64'(done_cnt_o), 64'd3);
    chk("t38_issue_cnt", 64'(issue_cnt_o), 64'd3);
`else
    chk("t38_done_cnt", 64'(done_cnt_o), 64'd0);
    chk("t38_issue_cnt", 64'(issue_cnt_o), 64'd0);
`endif
    step();
    chk("t38_done_low", 64'(done_o), 64'd0);

    // Full FIFO with stalled cores, then one core accepts.
    do_reset();
    push(20); push(21); push(22); push(23);
    chk("t37_count4", 64'(fifo_count_o), 64'd4);
    chk("t37_ready_low", 64'(req_ready_o), 64'd0);
    exp_q.push_back(ex(0, 20));
    core_ready_i = 2'b01;
    step();
    chk("t37_count3", 64'(fifo_count_o), 64'd3);
    chk("t37_ready_high", 64'(req_ready_o), 64'd1);
    core_ready_i = 2'b00;
    step();
    // Asynchronous reset mid-operation clears everything immediately.
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t39_rst_count", 64'(fifo_count_o), 64'd0);
    chk("t39_rst_valid", 64'(core_valid_o), 64'd0);
    chk("t39_rst_ready", 64'(req_ready_o), 64'd1);
    step();
    rst_ni = 1'b1;
    step();

    // Stale done on an idle core is ignored.
    core_done_i = 2'b10;
    step();
    core_done_i = 2'b00;
    chk("t39_stale_done", 64'(done_o), 64'd0);
    chk("t39_stale_idle", 64'(idle_o), 64'd1);
    core_ready_i = 2'b11;
    exp_q.push_back(ex(0, 30));
    push(30);
    step();
    core_done_i = 2'b01;
    step();
    core_done_i = 2'b00;

    // Streaming: cores complete every cycle, issues alternate, pointers wrap.
    do_reset();
    core_ready_i = 2'b11;
    core_done_i = 2'b11;
    for (int i = 0; i < 8; i++) exp_q.push_back(ex(i % 2, 40 + i));
    for (int i = 0; i < 8; i++) push(40 + i);
    repeat (4) step();
    core_done_i = 2'b00;
    step();
    chk("stream_idle", 64'(idle_o), 64'd1);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
